// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN      = 32;
  localparam int ITER_BITS = 5;
  localparam logic [ITER_BITS-1:0] LAST_ITER = 5'd31;

  // Operation encodings as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // Absolute value of a two's-complement operand when the op is signed.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[XLEN-1]) ? ('0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// 64-bit accumulator plus one shift-add / restoring-subtract iteration.
// Multiply: low half starts as the multiplier and drains out while the
// product grows in from the top. Divide: low half starts as the dividend
// and fills with quotient bits; the high half is the partial remainder.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic               rem_ge;

  // One iteration; the remainder is kept one bit wider across the shift so
  // that 2*r+1 never loses its top bit before the compare.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    rem_diff  = {1'b0, rem_shift} - {2'b00, opnd_reg};
    rem_ge    = ~rem_diff[WIDTH+1];
    acc_next  = acc_reg;
    if (is_div_reg) begin
      acc_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                  acc_reg[WIDTH-2:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  // Load operands on accept, then iterate once per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
    end else if (load) begin
      is_div_reg <= is_div;
      acc_reg    <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      opnd_reg   <= is_div ? b_mag : a_mag;
    end else if (step) begin
      acc_reg    <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with fixed 34-cycle occupancy:
// accept edge, 32 iteration edges, one sign fix-up/writeback edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e                state_reg;
  logic [ITER_BITS-1:0]  count_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [WIDTH-1:0]      hi_reg;
  logic [WIDTH-1:0]      lo_reg;
  op_e                   op_reg;
  logic [WIDTH-1:0]      a_reg;
  logic                  neg_a_reg;
  logic                  neg_b_reg;
  logic                  b_zero_reg;

  op_e                   op_dec;
  logic                  dec_signed;
  logic                  dec_div;
  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic                  accept;
  logic [2*WIDTH-1:0]    acc;
  logic [WIDTH-1:0]      hi_next;
  logic [WIDTH-1:0]      lo_next;

  // Decode the incoming request and take operand magnitudes.
  always_comb begin
    op_dec     = op_e'(op);
    dec_signed = op_is_signed(op_dec);
    dec_div    = op_is_div(op_dec);
    a_mag      = magnitude(A, dec_signed);
    b_mag      = magnitude(B, dec_signed);
    accept     = (state_reg == ST_IDLE) && start;
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state_reg == ST_CALC),
    .is_div (dec_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc)
  );

  // Sign fix-up of the unsigned result. Sign flags are only set for signed
  // ops, so unsigned results pass straight through. A zero divisor returns
  // the raw dividend in hi, not its magnitude. The most-negative / -1 case
  // needs no special handling: negating 0x80000000 wraps back to itself.
  always_comb begin
    hi_next = acc[2*WIDTH-1:WIDTH];
    lo_next = acc[WIDTH-1:0];
    if (op_is_div(op_reg)) begin
      if (b_zero_reg) begin
        lo_next = '1;
        hi_next = a_reg;
      end else begin
        if (neg_a_reg ^ neg_b_reg) lo_next = '0 - acc[WIDTH-1:0];
        if (neg_a_reg)             hi_next = '0 - acc[2*WIDTH-1:WIDTH];
      end
    end else if (neg_a_reg ^ neg_b_reg) begin
      {hi_next, lo_next} = '0 - acc;
    end
  end

  // Sequencer, iteration counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      op_reg     <= OP_MULT;
      a_reg      <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_CALC;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
            op_reg     <= op_dec;
            a_reg      <= A;
            neg_a_reg  <= dec_signed & A[WIDTH-1];
            neg_b_reg  <= dec_signed & B[WIDTH-1];
            b_zero_reg <= (B == '0);
          end else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        end
        ST_CALC: begin
          count_reg <= count_reg + 5'd1;
          if (count_reg == LAST_ITER) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          hi_reg    <= hi_next;
          lo_reg    <= lo_next;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          count_reg <= '0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port A  input  32  multiplicand or dividend (rs).
REQ-007 SHALL have port B  input  32  multiplier or divisor (rt).
REQ-008 SHALL have port wdata  input  32  data for mthi/mtlo.
REQ-009 SHALL have port mthi  input  1  write wdata to hi.
REQ-010 SHALL have port mtlo  input  1  write wdata to lo.
REQ-011 SHALL have port busy  output  1  operation in progress; the pipeline stalls mfhi/mflo/mult/div while high.
REQ-012 SHALL have port done  output  1  one-cycle pulse, hi/lo hold the new result.
REQ-013 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX; IDLE->CALC on start, CALC->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-015 SHALL latch A, B and op on the edge that accepts start (edge k); later input changes SHALL NOT affect the result.
REQ-016 SHALL perform one shift-add (multiply) or restoring-subtract (divide) iteration per CALC cycle, tracked by a 5-bit counter 0..31.
REQ-017 SHALL run signed ops on operand magnitudes and apply sign fix-up in FIX.
REQ-018 SHALL, on the FIX edge (k+33), write hi/lo, and done SHALL be 1 for exactly the cycle after edge k+33.
REQ-019 SHALL drive busy=1 from after edge k through edge k+33, and busy=0 in the done cycle.
REQ-020 SHALL use fixed latency for all ops and operand values, including the special cases below.
REQ-021 SHALL set {hi,lo} to the full 64-bit product for MULT (signed) and MULTU (unsigned).
REQ-022 SHALL set lo=quotient and hi=remainder for DIV/DIVU; signed quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-023 SHALL set lo=32'hFFFFFFFF and hi=A for a zero divisor, both DIV and DIVU.
REQ-024 SHALL set lo=32'h80000000 and hi=0 for DIV 32'h80000000 / 32'hFFFFFFFF.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL accept start in the done cycle, since the state is IDLE.
REQ-027 SHALL write mthi/mtlo only in IDLE; they SHALL be ignored in CALC/FIX.
REQ-028 SHALL let start win on simultaneous start and mthi/mtlo in IDLE; the write is dropped.
REQ-029 SHALL write both registers on simultaneous mthi and mtlo.
REQ-030 SHALL hold hi/lo at their previous values until the FIX edge.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, aborting any operation in progress.
REQ-032 SHALL give rst priority over start, mthi and mtlo.

Structure
REQ-033 SHALL place op encodings (MULT, MULTU, DIV, DIVU) and state encodings in a shared package used with the decoder.
REQ-034 SHALL use one sub-module, muldiv_datapath, holding the 64-bit accumulator/remainder and one-iteration logic; the top holds the FSM, counter and hi/lo.

Verification
REQ-035 SHALL check MULT A=-3 (FFFFFFFD), B=7 -> done after edge k+33, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-036 SHALL check MULTU A=FFFFFFFF, B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-037 SHALL check DIV A=-7, B=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU A=7, B=0 -> lo=FFFFFFFF, hi=7.
REQ-038 SHALL check start plus changed A/B/op at k+5 and mtlo at k+10 -> ignored; result matches the original operands; lo is not the mtlo data.
REQ-039 SHALL check rst at k+12 of DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
REQ-040 SHALL check back-to-back start in the done cycle -> second op accepted, its done 34 cycles later; the first result stays visible meanwhile.
